// File: rtl/mmio_bridge.sv
// mmio_bridge: decodes the core data bus into RAM/keyboard/art windows, buffers bytes in FIFOs, raises keyboard IRQs
module mmio_bridge #(
  parameter logic [63:0] KEY_BASE   = 64'h0000_0000_0000_2000,
  parameter logic [63:0] ART_BASE   = 64'h0000_0000_0000_2010,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] bus_address,
  input  logic [63:0] bus_write_data,
  input  logic        bus_write_enable,
  input  logic        bus_read_enable,
  output logic [63:0] bus_read_data,
  output logic        ram_sel,
  input  logic [63:0] ram_read_data,
  input  logic [7:0]  key_data,
  input  logic        key_valid,
  output logic        key_ready,
  output logic [7:0]  art_data,
  output logic        art_valid,
  input  logic        art_ready,
  output logic [3:0]  interrupt_vector,
  input  logic        interrupt_ack,
  input  logic        interrupt_pending
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;
  logic [7:0]    r_key_mem [FIFO_DEPTH];
  logic [7:0]    r_art_mem [FIFO_DEPTH];
  logic [AW-1:0] r_key_wp, r_key_rp, r_art_wp, r_art_rp;
  logic [CW-1:0] r_key_cnt, r_art_cnt;
  logic          r_irq_en, r_art_ovf, r_rd_en_d, r_irq_req;
  logic [63:0]   r_rd_data;
  state_t        r_state;
  logic          w_key_data_sel, w_key_stat_sel, w_art_data_sel, w_art_stat_sel;
  logic          w_rd_first, w_key_empty, w_key_full, w_art_empty, w_art_full;
  logic          w_key_push, w_key_pop, w_art_wr, w_art_push, w_art_pop;
  logic [63:0]   w_rd_value;
  logic          w_unused;
  assign w_key_data_sel = bus_address == KEY_BASE;
  assign w_key_stat_sel = bus_address == KEY_BASE + 64'd8;
  assign w_art_data_sel = bus_address == ART_BASE;
  assign w_art_stat_sel = bus_address == ART_BASE + 64'd8;
  assign ram_sel        = !(w_key_data_sel || w_key_stat_sel || w_art_data_sel || w_art_stat_sel);
  assign w_rd_first     = bus_read_enable && !r_rd_en_d;
  assign w_key_empty    = r_key_cnt == '0;
  assign w_key_full     = r_key_cnt == CW'(FIFO_DEPTH);
  assign w_art_empty    = r_art_cnt == '0;
  assign w_art_full     = r_art_cnt == CW'(FIFO_DEPTH);
  assign key_ready      = !w_key_full;
  assign art_valid      = !w_art_empty;
  assign art_data       = r_art_mem[r_art_rp];
  assign w_key_push     = key_valid && key_ready;
  assign w_key_pop      = w_rd_first && w_key_data_sel && !w_key_empty;
  assign w_art_wr       = bus_write_enable && w_art_data_sel;
  assign w_art_push     = w_art_wr && !w_art_full;
  assign w_art_pop      = art_valid && art_ready;
  assign bus_read_data  = r_rd_data;
  assign interrupt_vector = {3'b0, r_irq_req};
  assign w_unused       = &{1'b0, bus_write_data[63:8]};
  assign w_rd_value = w_key_data_sel ? {56'b0, w_key_empty ? 8'h00 : r_key_mem[r_key_rp]} :
                      w_key_stat_sel ? {52'b0, 4'(r_key_cnt), 6'b0, r_irq_en, w_key_empty} :
                      w_art_stat_sel ? {52'b0, 4'(r_art_cnt), 5'b0, r_art_ovf, w_art_full, w_art_empty} :
                      w_art_data_sel ? 64'b0 : ram_read_data;
  // FIFO payload storage; validity is tracked by the pointers and counts
  always_ff @(posedge clk) begin
    if (w_key_push) r_key_mem[r_key_wp] <= key_data;
    if (w_art_push) r_art_mem[r_art_wp] <= bus_write_data[7:0];
  end
  // FIFO pointers/counts, control bits and edge-triggered read capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_key_wp  <= '0;
      r_key_rp  <= '0;
      r_key_cnt <= '0;
      r_art_wp  <= '0;
      r_art_rp  <= '0;
      r_art_cnt <= '0;
      r_irq_en  <= 1'b0;
      r_art_ovf <= 1'b0;
      r_rd_en_d <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_en_d <= bus_read_enable;
      if (w_rd_first) r_rd_data <= w_rd_value;
      if (w_key_push) r_key_wp <= r_key_wp + 1'b1;
      if (w_key_pop) r_key_rp <= r_key_rp + 1'b1;
      r_key_cnt <= r_key_cnt + CW'(w_key_push) - CW'(w_key_pop);
      if (w_art_push) r_art_wp <= r_art_wp + 1'b1;
      if (w_art_pop) r_art_rp <= r_art_rp + 1'b1;
      r_art_cnt <= r_art_cnt + CW'(w_art_push) - CW'(w_art_pop);
      if (w_art_wr && w_art_full) r_art_ovf <= 1'b1;
      else if (bus_write_enable && w_art_stat_sel && bus_write_data[2]) r_art_ovf <= 1'b0;
      if (bus_write_enable && w_key_stat_sel) r_irq_en <= bus_write_data[1];
    end
  end
  // Keyboard interrupt request/ack handshake with the core
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_irq_req <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (r_irq_en && !w_key_empty && !interrupt_pending) begin
          r_state   <= S_REQ;
          r_irq_req <= 1'b1;
        end
        S_REQ: if (!r_irq_en || interrupt_ack) begin
          r_state   <= r_irq_en ? S_SERVICE : S_IDLE;
          r_irq_req <= 1'b0;
        end
        S_SERVICE: if (!interrupt_pending) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_bridge.sv
// tb_mmio_bridge: directed checks of decode, FIFOs, read capture and the interrupt handshake
module tb_mmio_bridge;
  localparam logic [63:0] KEY_DATA = 64'h2000;
  localparam logic [63:0] KEY_STAT = 64'h2008;
  localparam logic [63:0] ART_DATA = 64'h2010;
  localparam logic [63:0] ART_STAT = 64'h2018;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] bus_address = '0, bus_write_data = '0, ram_read_data = '0;
  logic        bus_write_enable = 1'b0, bus_read_enable = 1'b0;
  logic [63:0] bus_read_data;
  logic        ram_sel, key_ready, art_valid;
  logic [7:0]  key_data = '0, art_data;
  logic        key_valid = 1'b0, art_ready = 1'b0;
  logic [3:0]  interrupt_vector;
  logic        interrupt_ack = 1'b0, interrupt_pending = 1'b0;
  int          n_checks = 0, n_errors = 0;
  logic [63:0] rd;
  mmio_bridge dut (
    .clk(clk), .reset(reset), .bus_address(bus_address), .bus_write_data(bus_write_data),
    .bus_write_enable(bus_write_enable), .bus_read_enable(bus_read_enable),
    .bus_read_data(bus_read_data), .ram_sel(ram_sel), .ram_read_data(ram_read_data),
    .key_data(key_data), .key_valid(key_valid), .key_ready(key_ready),
    .art_data(art_data), .art_valid(art_valid), .art_ready(art_ready),
    .interrupt_vector(interrupt_vector), .interrupt_ack(interrupt_ack),
    .interrupt_pending(interrupt_pending)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic bus_write(input logic [63:0] a, input logic [63:0] d);
    @(negedge clk);
    bus_address = a;
    bus_write_data = d;
    bus_write_enable = 1'b1;
    @(negedge clk);
    bus_write_enable = 1'b0;
  endtask
  task automatic bus_read(input logic [63:0] a, output logic [63:0] d);
    @(negedge clk);
    bus_address = a;
    bus_read_enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus_read_enable = 1'b0;
    d = bus_read_data;
  endtask
  task automatic key_push(input logic [7:0] b);
    @(negedge clk);
    key_data = b;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    repeat (2) @(negedge clk);
    check("rst_rdata", bus_read_data, 64'h0);
    check("rst_art_valid", {63'b0, art_valid}, 64'h0);
    check("rst_key_ready", {63'b0, key_ready}, 64'h1);
    check("rst_vector", {60'b0, interrupt_vector}, 64'h0);
    reset = 1'b1;
    @(negedge clk);
    key_data = 8'h11;
    key_valid = 1'b1;
    bus_address = ART_DATA;
    bus_write_data = 64'h22;
    bus_write_enable = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    key_valid = 1'b0;
    bus_write_enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("midrst_art_valid", {63'b0, art_valid}, 64'h0);
    check("midrst_key_ready", {63'b0, key_ready}, 64'h1);
    bus_read(KEY_STAT, rd);
    check("midrst_key_stat", rd, 64'h1);
    bus_read(ART_STAT, rd);
    check("midrst_art_stat", rd, 64'h1);
    key_push(8'h41);
    key_push(8'h42);
    bus_read(KEY_DATA, rd);
    check("key_rd1", rd, 64'h41);
    bus_read(KEY_STAT, rd);
    check("key_one_pop", rd, 64'h100);
    bus_read(KEY_DATA, rd);
    check("key_rd2", rd, 64'h42);
    bus_read(KEY_DATA, rd);
    check("key_rd_empty", rd, 64'h0);
    bus_read(KEY_STAT, rd);
    check("key_stat_empty", rd, 64'h1);
    bus_write(ART_DATA, 64'h48);
    bus_write(ART_DATA, 64'h49);
    check("art_valid2", {63'b0, art_valid}, 64'h1);
    check("art_head", {56'b0, art_data}, 64'h48);
    bus_read(ART_STAT, rd);
    check("art_stat2", rd, 64'h200);
    bus_read(ART_DATA, rd);
    check("art_data_rd0", rd, 64'h0);
    @(negedge clk);
    art_ready = 1'b1;
    @(negedge clk);
    check("art_drain2", {56'b0, art_data}, 64'h49);
    @(negedge clk);
    check("art_drained", {63'b0, art_valid}, 64'h0);
    art_ready = 1'b0;
    for (int i = 0; i < 9; i++) bus_write(ART_DATA, 64'h50 + 64'(i));
    bus_read(ART_STAT, rd);
    check("art_full_ovf", rd, 64'h806);
    bus_write(ART_STAT, 64'h4);
    bus_read(ART_STAT, rd);
    check("art_ovf_clr", rd, 64'h802);
    @(negedge clk);
    bus_address = ART_DATA;
    bus_write_data = 64'h99;
    bus_write_enable = 1'b1;
    art_ready = 1'b1;
    @(negedge clk);
    bus_write_enable = 1'b0;
    art_ready = 1'b0;
    bus_read(ART_STAT, rd);
    check("art_full_pushpop", rd, 64'h704);
    @(negedge clk);
    art_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      check("art_order", {56'b0, art_data}, 64'h50 + 64'(i));
      @(negedge clk);
    end
    check("art_empty_after", {63'b0, art_valid}, 64'h0);
    art_ready = 1'b0;
    bus_write(ART_STAT, 64'h4);
    bus_write(KEY_STAT, 64'h2);
    bus_read(KEY_STAT, rd);
    check("irq_en_stat", rd, 64'h3);
    key_push(8'h0D);
    check("irq_not_yet", {60'b0, interrupt_vector}, 64'h0);
    @(negedge clk);
    check("irq_req", {60'b0, interrupt_vector}, 64'h1);
    repeat (3) @(negedge clk);
    check("irq_hold", {60'b0, interrupt_vector}, 64'h1);
    interrupt_ack = 1'b1;
    interrupt_pending = 1'b1;
    @(negedge clk);
    interrupt_ack = 1'b0;
    check("irq_acked", {60'b0, interrupt_vector}, 64'h0);
    repeat (3) @(negedge clk);
    check("irq_pending_quiet", {60'b0, interrupt_vector}, 64'h0);
    bus_read(KEY_DATA, rd);
    check("irq_key", rd, 64'h0D);
    interrupt_pending = 1'b0;
    repeat (3) @(negedge clk);
    check("irq_idle", {60'b0, interrupt_vector}, 64'h0);
    key_push(8'h0A);
    @(negedge clk);
    check("irq_req2", {60'b0, interrupt_vector}, 64'h1);
    bus_write(KEY_STAT, 64'h0);
    @(negedge clk);
    check("irq_cancel", {60'b0, interrupt_vector}, 64'h0);
    bus_read(KEY_DATA, rd);
    check("irq_key2", rd, 64'h0A);
    for (int i = 0; i < 8; i++) key_push(8'h60 + 8'(i));
    check("key_full_ready", {63'b0, key_ready}, 64'h0);
    bus_read(KEY_STAT, rd);
    check("key_stat_full", rd, 64'h800);
    @(negedge clk);
    bus_address = KEY_DATA;
    bus_read_enable = 1'b1;
    key_data = 8'hAA;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    @(negedge clk);
    bus_read_enable = 1'b0;
    check("key_full_pop", bus_read_data, 64'h60);
    bus_read(KEY_STAT, rd);
    check("key_full_pushpop", rd, 64'h700);
    check("key_ready_again", {63'b0, key_ready}, 64'h1);
    for (int i = 1; i < 8; i++) begin
      bus_read(KEY_DATA, rd);
      check("key_order", rd, 64'h60 + 64'(i));
    end
    check("ram_sel_key", {63'b0, ram_sel}, 64'h0);
    ram_read_data = 64'hDEAD_BEEF_1234_5678;
    @(negedge clk);
    bus_address = 64'h1000;
    #1 check("ram_sel", {63'b0, ram_sel}, 64'h1);
    bus_read(64'h1000, rd);
    check("ram_read", rd, 64'hDEAD_BEEF_1234_5678);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
